// File: rtl/q_loop_pkg.sv
// Shared types and helpers for the multi-channel Q control loop.
package q_loop_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    SETTLE,
    MEASURE,
    UPDATE,
    NEXT
  } state_e;

  // Channel index width: clog2 of the channel count, never narrower than one bit.
  function automatic int chIdxWidth(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Product of a pulse count and a scale factor, clamped to maxVal.
  function automatic logic [31:0] satMul(input logic [31:0] count,
                                         input logic [31:0] scale,
                                         input logic [31:0] maxVal);
    logic [63:0] prod;
    prod = {32'd0, count} * {32'd0, scale};
    if (prod > {32'd0, maxVal}) return maxVal;
    return prod[31:0];
  endfunction

endpackage

// File: rtl/q_pulse_window.sv
// Synchronizes every channel's Q pulse stream and counts rising edges of the
// selected channel over one fixed-length window, then scales the count to Q.
module q_pulse_window
  import q_loop_pkg::*;
#(
  parameter int BUS_WIDTH   = 10,
  parameter int N_CH        = 4,
  parameter int Q_PER_PULSE = 30,
  parameter int WINDOW_LEN  = 64,
  parameter int CH_W        = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_CH-1:0]      q_serialized_i,
  input  logic [CH_W-1:0]      sel_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  output logic                 done_o,
  output logic [BUS_WIDTH-1:0] q_o
);

  localparam int CNT_W = $clog2(WINDOW_LEN + 1);
  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW_LEN - 1);
  localparam logic [31:0] Q_MAX = (32'd1 << BUS_WIDTH) - 32'd1;

  logic [N_CH-1:0]  sync1_q, sync2_q, prev_q, pulseEdge;
  logic             selEdge;
  logic             active_q;
  logic [CNT_W-1:0] winCnt_q, pulseCnt_q;
  logic [31:0]      qFull;

  // Two-flop synchronizer plus a delayed copy for rising-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= q_serialized_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign pulseEdge = sync2_q & ~prev_q;

  // Pick out the edge strobe of the channel being measured.
  always_comb begin
    selEdge = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      if (sel_i == CH_W'(c)) selEdge = pulseEdge[c];
    end
  end

  // Window timer and saturating edge counter; start clears, abort closes early.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_q    <= 1'b0;
      winCnt_q    <= '0;
      pulseCnt_q  <= '0;
    end else if (abort_i) begin
      active_q    <= 1'b0;
    end else if (start_i) begin
      active_q    <= 1'b1;
      winCnt_q    <= '0;
      pulseCnt_q  <= '0;
    end else if (active_q) begin
      if (selEdge && (pulseCnt_q != '1)) pulseCnt_q <= pulseCnt_q + 1'b1;
      if (winCnt_q == WIN_LAST) active_q <= 1'b0;
      else winCnt_q <= winCnt_q + 1'b1;
    end
  end

  assign done_o = active_q && (winCnt_q == WIN_LAST);
  assign qFull  = satMul(32'(pulseCnt_q), 32'(Q_PER_PULSE), Q_MAX);
  assign q_o    = qFull[BUS_WIDTH-1:0];

endmodule

// File: rtl/q_loop_mc.sv
// Round-robin Q control across N_CH resonators: one shared measurement window
// and one bisection update step, with per-channel search bounds and flags.
module q_loop_mc
  import q_loop_pkg::*;
#(
  parameter int BUS_WIDTH     = 10,
  parameter int N_CH          = 4,
  parameter int Q_PER_PULSE   = 30,
  parameter int WINDOW_LEN    = 64,
  parameter int SETTLE_CYCLES = 8,
  parameter int I_REF_MAX     = 2**BUS_WIDTH - 1,
  parameter int TOL           = 1,
  parameter int RELOCK_TOL    = 4,
  localparam int CH_W         = chIdxWidth(N_CH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_CH-1:0]           enable,
  input  logic [N_CH-1:0]           q_serialized,
  input  logic [N_CH*BUS_WIDTH-1:0] q_desired,
  output logic [N_CH*BUS_WIDTH-1:0] i_ref_out,
  output logic [N_CH-1:0]           locked,
  output logic [N_CH-1:0]           fail,
  output logic                      busy,
  output logic                      meas_valid,
  output logic [CH_W-1:0]           meas_ch,
  output logic [BUS_WIDTH-1:0]      q_measured
);

  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SET_W-1:0]     SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [BUS_WIDTH-1:0] MAX_V    = BUS_WIDTH'(I_REF_MAX);
  localparam logic [BUS_WIDTH-1:0] MID_V    = MAX_V >> 1;
  localparam logic [BUS_WIDTH-1:0] TOL_V    = BUS_WIDTH'(TOL);
  localparam logic [BUS_WIDTH-1:0] RELOCK_V = BUS_WIDTH'(RELOCK_TOL);

  state_e               state_q;
  logic [CH_W-1:0]      ptr_q, sel_q, pick, nextPtr;
  logic [SET_W-1:0]     settleCnt_q;
  logic                 busy_q, measValid_q, found;
  logic [CH_W-1:0]      measCh_q;
  logic [BUS_WIDTH-1:0] qMeas_q, qNow;

  logic [BUS_WIDTH-1:0] lo_q [N_CH];
  logic [BUS_WIDTH-1:0] hi_q [N_CH];
  logic [BUS_WIDTH-1:0] cur_q[N_CH];
  logic [N_CH-1:0]      locked_q, fail_q;

  logic [BUS_WIDTH-1:0] loSel, hiSel, curSel, dSel, err;
  logic                 lockedSel, failSel, selEn;
  logic [BUS_WIDTH-1:0] updLo, updHi, updCur;
  logic                 updLocked, updFail, moved;
  logic [BUS_WIDTH:0]   nLo, nHi, sum;
  logic                 winStart, winAbort, winDone;

  q_pulse_window #(
    .BUS_WIDTH  (BUS_WIDTH),
    .N_CH       (N_CH),
    .Q_PER_PULSE(Q_PER_PULSE),
    .WINDOW_LEN (WINDOW_LEN),
    .CH_W       (CH_W)
  ) u_window (
    .clk           (clk),
    .rst           (rst),
    .q_serialized_i(q_serialized),
    .sel_i         (sel_q),
    .start_i       (winStart),
    .abort_i       (winAbort),
    .done_o        (winDone),
    .q_o           (qNow)
  );

  // First enabled channel at or after the pointer, wrapping around.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      int idx;
      idx = int'(ptr_q) + i;
      if (idx >= N_CH) idx = idx - N_CH;
      if (enable[idx]) begin
        found = 1'b1;
        pick  = CH_W'(idx);
      end
    end
    nextPtr = (int'(sel_q) + 1 >= N_CH) ? '0 : sel_q + 1'b1;
  end

  // Mux out the selected channel's search state and target.
  always_comb begin
    loSel     = lo_q[0];
    hiSel     = hi_q[0];
    curSel    = cur_q[0];
    lockedSel = locked_q[0];
    failSel   = fail_q[0];
    selEn     = enable[0];
    dSel      = q_desired[BUS_WIDTH-1:0];
    for (int c = 1; c < N_CH; c++) begin
      if (sel_q == CH_W'(c)) begin
        loSel     = lo_q[c];
        hiSel     = hi_q[c];
        curSel    = cur_q[c];
        lockedSel = locked_q[c];
        failSel   = fail_q[c];
        selEn     = enable[c];
        dSel      = q_desired[c*BUS_WIDTH +: BUS_WIDTH];
      end
    end
  end

  // One bisection step for the selected channel from the fresh measurement.
  always_comb begin
    updLo     = loSel;
    updHi     = hiSel;
    updCur    = curSel;
    updLocked = lockedSel;
    updFail   = failSel;
    moved     = 1'b0;
    nLo       = {1'b0, loSel};
    nHi       = {1'b0, hiSel};
    sum       = '0;
    err       = (qNow > dSel) ? (qNow - dSel) : (dSel - qNow);
    if (lockedSel) begin
      if (err > RELOCK_V) begin
        updLocked = 1'b0;
        updLo     = '0;
        updHi     = MAX_V;
        updCur    = MID_V;
      end
    end else if (!failSel) begin
      if (err <= TOL_V) begin
        updLocked = 1'b1;
      end else if (qNow < dSel) begin
        if (curSel == MAX_V) updFail = 1'b1;
        else begin
          nLo   = {1'b0, curSel} + 1'b1;
          moved = 1'b1;
        end
      end else begin
        if (curSel == '0) updFail = 1'b1;
        else begin
          nHi   = {1'b0, curSel} - 1'b1;
          moved = 1'b1;
        end
      end
      if (moved) begin
        updLo = nLo[BUS_WIDTH-1:0];
        updHi = nHi[BUS_WIDTH-1:0];
        if (nLo > nHi) updFail = 1'b1;
        else begin
          sum    = nLo + nHi;
          updCur = sum[BUS_WIDTH:1];
        end
      end
    end
  end

  // Per-channel search registers: forced to the start point while disabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < N_CH; c++) begin
        lo_q[c]     <= '0;
        hi_q[c]     <= MAX_V;
        cur_q[c]    <= MID_V;
        locked_q[c] <= 1'b0;
        fail_q[c]   <= 1'b0;
      end
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (!enable[c]) begin
          lo_q[c]     <= '0;
          hi_q[c]     <= MAX_V;
          cur_q[c]    <= MID_V;
          locked_q[c] <= 1'b0;
          fail_q[c]   <= 1'b0;
        end else if ((state_q == UPDATE) && (sel_q == CH_W'(c))) begin
          lo_q[c]     <= updLo;
          hi_q[c]     <= updHi;
          cur_q[c]    <= updCur;
          locked_q[c] <= updLocked;
          fail_q[c]   <= updFail;
        end
      end
    end
  end

  assign winStart = (state_q == SETTLE) && selEn && (settleCnt_q == SETTLE_LAST);
  assign winAbort = ((state_q == SETTLE) || (state_q == MEASURE)) && !selEn;

  // Scheduler: visit enabled channels in turn, skipping idle ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      sel_q       <= '0;
      settleCnt_q <= '0;
      busy_q      <= 1'b0;
      measValid_q <= 1'b0;
      measCh_q    <= '0;
      qMeas_q     <= '0;
    end else begin
      measValid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|enable) begin
            state_q <= SELECT;
            busy_q  <= 1'b1;
          end
        end
        SELECT: begin
          if (found) begin
            sel_q       <= pick;
            settleCnt_q <= '0;
            state_q     <= SETTLE;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        SETTLE: begin
          if (!selEn) state_q <= NEXT;
          else if (settleCnt_q == SETTLE_LAST) state_q <= MEASURE;
          else settleCnt_q <= settleCnt_q + 1'b1;
        end
        MEASURE: begin
          if (!selEn) state_q <= NEXT;
          else if (winDone) state_q <= UPDATE;
        end
        UPDATE: begin
          measValid_q <= 1'b1;
          measCh_q    <= sel_q;
          qMeas_q     <= qNow;
          state_q     <= NEXT;
        end
        NEXT: begin
          ptr_q   <= nextPtr;
          state_q <= SELECT;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_iref
    assign i_ref_out[c*BUS_WIDTH +: BUS_WIDTH] = enable[c] ? cur_q[c] : '0;
  end

  assign locked     = locked_q;
  assign fail       = fail_q;
  assign busy       = busy_q;
  assign meas_valid = measValid_q;
  assign meas_ch    = measCh_q;
  assign q_measured = qMeas_q;

endmodule

// File: tb/tb_q_loop_mc.sv
// Directed bench for q_loop_mc: a behavioural resonator plant on one channel
// of a 4-channel instance, plus a 1-channel long-window instance for saturation.
module tb_q_loop_mc;

  localparam int BW  = 10;
  localparam int NCH = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NCH-1:0]  enable, qSer, locked, fail;
  logic [NCH*BW-1:0] qDes, iRef;
  logic            busy, measValid;
  logic [1:0]      measCh;
  logic [BW-1:0]   qMeas;

  logic            sEnable, sQSer, sLocked, sFail, sBusy, sMeasValid, satOn;
  logic [0:0]      sMeasCh;
  logic [BW-1:0]   sQDes, sIRef, sQMeas;

  int checks = 0;
  int errors = 0;
  int plantCh = 0;
  int visits;

  always #5 clk = ~clk;

  q_loop_mc dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .q_serialized(qSer),
    .q_desired   (qDes),
    .i_ref_out   (iRef),
    .locked      (locked),
    .fail        (fail),
    .busy        (busy),
    .meas_valid  (measValid),
    .meas_ch     (measCh),
    .q_measured  (qMeas)
  );

  q_loop_mc #(.N_CH(1), .WINDOW_LEN(256)) sdut (
    .clk         (clk),
    .rst         (rst),
    .enable      (sEnable),
    .q_serialized(sQSer),
    .q_desired   (sQDes),
    .i_ref_out   (sIRef),
    .locked      (sLocked),
    .fail        (sFail),
    .busy        (sBusy),
    .meas_valid  (sMeasValid),
    .meas_ch     (sMeasCh),
    .q_measured  (sQMeas)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rstVal, input logic [NCH-1:0] enVal,
                               input logic [NCH*BW-1:0] desVal);
    rst    = rstVal;
    enable = enVal;
    qDes   = desVal;
  endtask

  task automatic waitMeas(input int budget, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!measValid && n < budget);
    if (!measValid) checkOutput({tag, "_timeout"}, 0, 1);
  endtask

  // Plant: round(i_ref/16) pulses per window, capped at 30 (Q saturates at 900).
  // Phase 0 is the cycle after an UPDATE, phase 1 the SELECT cycle; the
  // window then spans cycles 10..73, so pulses are driven on cycles 8, 10, ...
  initial begin : plant
    int phase, nPulses, iv;
    logic busyPrev;
    phase    = 1000;
    nPulses  = 0;
    busyPrev = 1'b0;
    qSer     = '0;
    forever begin
      @(negedge clk);
      if (measValid) phase = 0;
      else if (busy && !busyPrev) phase = 1;
      else phase++;
      busyPrev = busy;
      if (phase <= 1) begin
        iv      = int'(iRef[plantCh*BW +: BW]);
        nPulses = (iv + 8) / 16;
        if (nPulses > 30) nPulses = 30;
      end
      qSer = '0;
      if (phase >= 8 && ((phase - 8) % 2 == 0) && ((phase - 8) / 2 < nPulses))
        qSer[plantCh] = 1'b1;
    end
  end

  // Flood source for the saturation instance: an edge every two cycles.
  initial begin : flood
    sQSer = 1'b0;
    forever begin
      @(negedge clk);
      sQSer = satOn ? ~sQSer : 1'b0;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int n;
    sEnable = 1'b0;
    sQDes   = '0;
    satOn   = 1'b0;
    applyStimulus(1'b0, '0, '0);
    repeat (3) @(negedge clk);

    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_mvalid", measValid, 0);
    checkOutput("rst_qmeas", qMeas, 0);
    checkOutput("rst_mch", measCh, 0);
    checkOutput("rst_iref_disabled", iRef[BW-1:0], 0);
    checkOutput("rst_locked", locked, 0);
    checkOutput("rst_fail", fail, 0);

    applyStimulus(1'b1, 4'b1111, {4{10'd300}});
    repeat (30) @(negedge clk);
    checkOutput("run_busy", busy, 1);
    applyStimulus(1'b0, 4'b1111, {4{10'd300}});
    #1;
    for (int c = 0; c < NCH; c++)
      checkOutput($sformatf("midrst_iref%0d", c), iRef[c*BW +: BW], 10'h1FF);
    checkOutput("midrst_locked", locked, 0);
    checkOutput("midrst_fail", fail, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_mvalid", measValid, 0);
    @(negedge clk);
    applyStimulus(1'b1, 4'b1111, {4{10'd300}});
    n = 0;
    while (!busy && n < 4) begin
      @(negedge clk);
      n++;
    end
    checkOutput("busy_within_2", (n <= 2) && busy, 1);

    applyStimulus(1'b0, 4'b0001, 40'd300);
    plantCh = 0;
    @(negedge clk);
    applyStimulus(1'b1, 4'b0001, 40'd300);
    visits = 0;
    while (visits < 10 && !locked[0]) begin
      waitMeas(100, "conv");
      visits++;
    end
    checkOutput("conv_locked", locked[0], 1);
    checkOutput("conv_visits", visits, 5);
    checkOutput("conv_q", qMeas, 300);
    checkOutput("conv_iref", iRef[BW-1:0], 159);
    repeat (3) waitMeas(100, "hold");
    checkOutput("hold_iref", iRef[BW-1:0], 159);
    checkOutput("hold_locked", locked[0], 1);

    applyStimulus(1'b1, 4'b0001, 40'd600);
    waitMeas(100, "relock");
    checkOutput("relock_drop", locked[0], 0);
    checkOutput("relock_restart", iRef[BW-1:0], 511);
    checkOutput("relock_oldq", qMeas, 300);
    visits = 0;
    while (visits < 10 && !locked[0]) begin
      waitMeas(100, "relock_conv");
      visits++;
    end
    checkOutput("relock_locked", locked[0], 1);
    checkOutput("relock_visits", visits, 4);
    checkOutput("relock_q", qMeas, 600);
    checkOutput("relock_iref", iRef[BW-1:0], 319);

    applyStimulus(1'b1, 4'b0000, 40'd1000);
    repeat (6) @(negedge clk);
    checkOutput("dis_iref", iRef[BW-1:0], 0);
    checkOutput("dis_idle", busy, 0);
    applyStimulus(1'b1, 4'b0001, 40'd1000);
    visits = 0;
    while (visits < 15 && !fail[0]) begin
      waitMeas(100, "fail");
      visits++;
    end
    checkOutput("fail_set", fail[0], 1);
    checkOutput("fail_visits", visits, 11);
    checkOutput("fail_iref", iRef[BW-1:0], 1023);
    checkOutput("fail_locked", locked[0], 0);
    repeat (2) waitMeas(100, "fail_hold");
    checkOutput("fail_hold_iref", iRef[BW-1:0], 1023);
    checkOutput("fail_hold_flag", fail[0], 1);
    applyStimulus(1'b1, 4'b0000, 40'd1000);
    repeat (5) @(negedge clk);
    checkOutput("fail_clear", fail[0], 0);
    applyStimulus(1'b1, 4'b0001, 40'd1000);
    #1;
    checkOutput("reenable_iref", iRef[BW-1:0], 511);
    @(negedge clk);
    checkOutput("reenable_fail", fail[0], 0);

    applyStimulus(1'b0, 4'b1010, '0);
    @(negedge clk);
    applyStimulus(1'b1, 4'b1010, '0);
    for (int k = 0; k < 5; k++) begin
      waitMeas(100, "rr");
      checkOutput($sformatf("rr_ch%0d", k), measCh, (k % 2 == 0) ? 1 : 3);
    end
    repeat (40) @(negedge clk);
    applyStimulus(1'b1, 4'b0010, '0);
    @(negedge clk);
    checkOutput("abort_iref3", iRef[3*BW +: BW], 0);
    waitMeas(150, "abort");
    checkOutput("abort_next_ch", measCh, 1);

    sEnable = 1'b1;
    satOn   = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sMeasValid && n < 400);
    checkOutput("sat_valid", sMeasValid, 1);
    checkOutput("sat_q", sQMeas, 1023);
    checkOutput("sat_ch", sMeasCh, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
